// File: rtl/sargantana_icache_refill.sv
// Sargantana instruction-cache line refill: requests a missing line, assembles its beats and
// writes the line into the chosen victim way. Define ICACHE_EARLY_FWD_EN to forward the fetched chunk early.
module sargantana_icache_refill #(
  parameter int TAG_WIDHT        = 20,
  parameter int ICACHE_IDX_WIDTH = 6,
  parameter int ICACHE_N_WAY     = 4,
  parameter int WAY_WIDHT        = 512,
  parameter int FETCH_WIDHT      = 256,
  parameter int BEAT_W           = 128,
  parameter int N_BEATS          = WAY_WIDHT / BEAT_W
) (
  input  logic                        clk_i,
  input  logic                        rstn_i,
  input  logic                        miss_i,
  input  logic [TAG_WIDHT-1:0]        miss_tag_i,
  input  logic [ICACHE_IDX_WIDTH-1:0] miss_idx_i,
  input  logic [1:0]                  fetch_idx_i,
  input  logic [ICACHE_N_WAY-1:0]     way_valid_bits_i,
  input  logic                        kill_i,
  output logic                        req_valid_o,
  input  logic                        req_ready_i,
  output logic [TAG_WIDHT-1:0]        req_tag_o,
  output logic [ICACHE_IDX_WIDTH-1:0] req_idx_o,
  input  logic                        resp_valid_i,
  input  logic [BEAT_W-1:0]           resp_data_i,
  output logic                        wr_en_o,
  output logic [ICACHE_N_WAY-1:0]     wr_way_o,
  output logic [ICACHE_IDX_WIDTH-1:0] wr_idx_o,
  output logic [TAG_WIDHT-1:0]        wr_tag_o,
  output logic [WAY_WIDHT-1:0]        wr_data_o,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        fwd_valid_o,
  output logic [FETCH_WIDHT-1:0]      fwd_data_o
);

  localparam int CNT_W = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
  localparam int RR_W  = (ICACHE_N_WAY > 1) ? $clog2(ICACHE_N_WAY) : 1;
  localparam logic [ICACHE_N_WAY-1:0] WAY_ONE = {{(ICACHE_N_WAY-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    WRITE = 2'd3
  } state_e;

  state_e                      state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [RR_W-1:0]             rr_q, rr_d;
  logic                        killed_q, killed_d;
  logic                        use_rr_q, use_rr_d;
  logic [TAG_WIDHT-1:0]        tag_q, tag_d;
  logic [ICACHE_IDX_WIDTH-1:0] idx_q, idx_d;
  logic [1:0]                  fidx_q, fidx_d;
  logic [ICACHE_N_WAY-1:0]     way_q, way_d;
  logic [WAY_WIDHT-1:0]        line_q, line_d;
  logic                        req_valid_q, req_valid_d;
  logic                        wr_en_q, wr_en_d;
  logic                        busy_q, busy_d;
  logic [ICACHE_N_WAY-1:0]     victim_way;
  logic                        free_found;
  logic                        victim_is_rr;

  // Victim selection: lowest free way, otherwise the round-robin way.
  always_comb begin
    victim_way = '0;
    free_found = 1'b0;
    for (int i = 0; i < ICACHE_N_WAY; i++) begin
      victim_way[i] = !way_valid_bits_i[i] && !free_found;
      free_found    = free_found || !way_valid_bits_i[i];
    end
    if (free_found) begin
      victim_is_rr = 1'b0;
    end else begin
      victim_is_rr = 1'b1;
      victim_way   = WAY_ONE << rr_q;
    end
  end

  // Next-state and datapath update of the refill FSM.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rr_d     = rr_q;
    killed_d = killed_q;
    use_rr_d = use_rr_q;
    tag_d    = tag_q;
    idx_d    = idx_q;
    fidx_d   = fidx_q;
    way_d    = way_q;
    line_d   = line_q;
    case (state_q)
      IDLE: begin
        if (miss_i) begin
          tag_d    = miss_tag_i;
          idx_d    = miss_idx_i;
          fidx_d   = fetch_idx_i;
          way_d    = victim_way;
          use_rr_d = victim_is_rr;
          killed_d = 1'b0;
          cnt_d    = '0;
          state_d  = REQ;
        end else begin
          state_d  = IDLE;
        end
      end
      REQ: begin
        // A kill coinciding with the handshake cannot retract the request, so it only marks the refill.
        if (req_ready_i) begin
          killed_d = kill_i;
          state_d  = WAIT;
        end else if (kill_i) begin
          state_d  = IDLE;
        end else begin
          state_d  = REQ;
        end
      end
      WAIT: begin
        if (kill_i) begin
          killed_d = 1'b1;
        end else begin
          killed_d = killed_q;
        end
        if (resp_valid_i) begin
          line_d[cnt_q*BEAT_W +: BEAT_W] = resp_data_i;
          if (cnt_q == CNT_W'(N_BEATS-1)) begin
            cnt_d   = '0;
            state_d = WRITE;
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = WAIT;
          end
        end else begin
          state_d = WAIT;
        end
      end
      WRITE: begin
        if (!killed_q && use_rr_q) begin
          rr_d = (rr_q == RR_W'(ICACHE_N_WAY-1)) ? '0 : rr_q + RR_W'(1);
        end else begin
          rr_d = rr_q;
        end
        killed_d = 1'b0;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    req_valid_d = (state_d == REQ);
    wr_en_d     = (state_d == WRITE) && !killed_d;
    busy_d      = (state_d != IDLE);
  end

  // State, latched request and registered control outputs.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rr_q        <= '0;
      killed_q    <= 1'b0;
      use_rr_q    <= 1'b0;
      tag_q       <= '0;
      idx_q       <= '0;
      fidx_q      <= 2'd0;
      way_q       <= '0;
      line_q      <= '0;
      req_valid_q <= 1'b0;
      wr_en_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rr_q        <= rr_d;
      killed_q    <= killed_d;
      use_rr_q    <= use_rr_d;
      tag_q       <= tag_d;
      idx_q       <= idx_d;
      fidx_q      <= fidx_d;
      way_q       <= way_d;
      line_q      <= line_d;
      req_valid_q <= req_valid_d;
      wr_en_q     <= wr_en_d;
      busy_q      <= busy_d;
    end
  end

  assign req_valid_o = req_valid_q;
  assign req_tag_o   = tag_q;
  assign req_idx_o   = idx_q;
  assign wr_en_o     = wr_en_q;
  assign done_o      = wr_en_q;
  assign wr_way_o    = way_q;
  assign wr_idx_o    = idx_q;
  assign wr_tag_o    = tag_q;
  assign wr_data_o   = line_q;
  assign busy_o      = busy_q;

`ifdef ICACHE_EARLY_FWD_EN
  assign fwd_valid_o = (state_q == WAIT) && resp_valid_i && (cnt_q == CNT_W'(fidx_q))
                       && !killed_q && !kill_i;
  assign fwd_data_o  = {{(FETCH_WIDHT-BEAT_W){1'b0}}, resp_data_i};
`else
  logic unused_fwd;
  assign unused_fwd  = ^fidx_q;
  assign fwd_valid_o = 1'b0;
  assign fwd_data_o  = '0;
`endif

endmodule

// File: tb/tb_sargantana_icache_refill.sv
// Directed bench for sargantana_icache_refill: expected line writes are queued at miss time
// and compared by a negedge monitor whenever the refill writes.
module tb_sargantana_icache_refill;

  localparam int TW = 20;
  localparam int IW = 6;
  localparam int NW = 4;
  localparam int WW = 512;
  localparam int FW = 256;
  localparam int BW = 128;

  logic          clk = 1'b0;
  logic          rstn_i;
  logic          miss_i;
  logic [TW-1:0] miss_tag_i;
  logic [IW-1:0] miss_idx_i;
  logic [1:0]    fetch_idx_i;
  logic [NW-1:0] way_valid_bits_i;
  logic          kill_i;
  logic          req_valid_o;
  logic          req_ready_i;
  logic [TW-1:0] req_tag_o;
  logic [IW-1:0] req_idx_o;
  logic          resp_valid_i;
  logic [BW-1:0] resp_data_i;
  logic          wr_en_o;
  logic [NW-1:0] wr_way_o;
  logic [IW-1:0] wr_idx_o;
  logic [TW-1:0] wr_tag_o;
  logic [WW-1:0] wr_data_o;
  logic          busy_o;
  logic          done_o;
  logic          fwd_valid_o;
  logic [FW-1:0] fwd_data_o;

  typedef struct packed {
    logic [NW-1:0] way;
    logic [TW-1:0] tag;
    logic [IW-1:0] idx;
    logic [WW-1:0] data;
  } wr_exp_t;

  wr_exp_t sb_q[$];
  wr_exp_t mon_e;
  int      total_cnt = 0;
  int      pass_cnt  = 0;
  int      cur_fidx;
  bit      cur_killed;

  always #5 clk = ~clk;

  sargantana_icache_refill dut (
    .clk_i            (clk),
    .rstn_i           (rstn_i),
    .miss_i           (miss_i),
    .miss_tag_i       (miss_tag_i),
    .miss_idx_i       (miss_idx_i),
    .fetch_idx_i      (fetch_idx_i),
    .way_valid_bits_i (way_valid_bits_i),
    .kill_i           (kill_i),
    .req_valid_o      (req_valid_o),
    .req_ready_i      (req_ready_i),
    .req_tag_o        (req_tag_o),
    .req_idx_o        (req_idx_o),
    .resp_valid_i     (resp_valid_i),
    .resp_data_i      (resp_data_i),
    .wr_en_o          (wr_en_o),
    .wr_way_o         (wr_way_o),
    .wr_idx_o         (wr_idx_o),
    .wr_tag_o         (wr_tag_o),
    .wr_data_o        (wr_data_o),
    .busy_o           (busy_o),
    .done_o           (done_o),
    .fwd_valid_o      (fwd_valid_o),
    .fwd_data_o       (fwd_data_o)
  );

  task automatic check(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt = pass_cnt + 1;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [BW-1:0] beat_val(input logic [31:0] seed, input int b);
    return {4{seed + 32'(b) * 32'h0101_0101}};
  endfunction

  function automatic logic [WW-1:0] line_val(input logic [31:0] seed);
    return {beat_val(seed, 3), beat_val(seed, 2), beat_val(seed, 1), beat_val(seed, 0)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every write strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (wr_en_o === 1'b1 || done_o === 1'b1) begin
      check("done_eq_wr_en", done_o, wr_en_o);
      if (sb_q.size() == 0) begin
        check("unexpected_write", wr_en_o, 1'b0);
      end else if (wr_en_o === 1'b1) begin
        mon_e = sb_q.pop_front();
        check("wr_way", wr_way_o, mon_e.way);
        check("wr_tag", wr_tag_o, mon_e.tag);
        check("wr_idx", wr_idx_o, mon_e.idx);
        check("wr_data", wr_data_o, mon_e.data);
      end
    end
  end

  task automatic start_miss(input logic [TW-1:0] tag, input logic [IW-1:0] idx, input logic [1:0] fidx,
                            input logic [NW-1:0] valid, input logic [NW-1:0] exp_way,
                            input bit push, input logic [31:0] seed);
    miss_i = 1'b1;
    miss_tag_i = tag;
    miss_idx_i = idx;
    fetch_idx_i = fidx;
    way_valid_bits_i = valid;
    cur_fidx = int'(fidx);
    cur_killed = 1'b0;
    if (push) sb_q.push_back('{way: exp_way, tag: tag, idx: idx, data: line_val(seed)});
    step();
    miss_i = 1'b0;
    way_valid_bits_i = '0;
    check("req_valid", req_valid_o, 1'b1);
    check("req_tag", req_tag_o, tag);
    check("req_idx", req_idx_o, idx);
    check("busy_req", busy_o, 1'b1);
  endtask

  task automatic handshake();
    req_ready_i = 1'b1;
    step();
    req_ready_i = 1'b0;
    check("req_valid_after_hs", req_valid_o, 1'b0);
  endtask

  task automatic send_beat(input logic [31:0] seed, input int b);
    bit exp_fwd;
    resp_valid_i = 1'b1;
    resp_data_i = beat_val(seed, b);
    #1;
`ifdef ICACHE_EARLY_FWD_EN
    exp_fwd = (b == cur_fidx) && !cur_killed;
`else
    exp_fwd = 1'b0;
`endif
    check("fwd_valid", fwd_valid_o, exp_fwd);
    if (exp_fwd) check("fwd_data", fwd_data_o, {{(FW-BW){1'b0}}, beat_val(seed, b)});
    step();
    resp_valid_i = 1'b0;
  endtask

  task automatic finish_write(input bit exp_wr);
    check("wr_en", wr_en_o, exp_wr);
    check("done", done_o, exp_wr);
    step();
    check("busy_idle", busy_o, 1'b0);
  endtask

  task automatic full_refill(input logic [TW-1:0] tag, input logic [IW-1:0] idx, input logic [1:0] fidx,
                             input logic [NW-1:0] valid, input logic [NW-1:0] exp_way,
                             input logic [31:0] seed);
    start_miss(tag, idx, fidx, valid, exp_way, 1'b1, seed);
    handshake();
    for (int b = 0; b < 4; b++) send_beat(seed, b);
    finish_write(1'b1);
  endtask

  initial begin
    rstn_i = 1'b0;
    miss_i = 1'b0;
    miss_tag_i = '0;
    miss_idx_i = '0;
    fetch_idx_i = 2'd0;
    way_valid_bits_i = '0;
    kill_i = 1'b0;
    req_ready_i = 1'b0;
    resp_valid_i = 1'b0;
    resp_data_i = '0;
    cur_fidx = 0;
    cur_killed = 1'b0;
    #2;
    check("rst_busy", busy_o, 1'b0);
    check("rst_req_valid", req_valid_o, 1'b0);
    check("rst_wr_en", wr_en_o, 1'b0);
    check("rst_done", done_o, 1'b0);
    check("rst_fwd", fwd_valid_o, 1'b0);
    step();
    step();
    rstn_i = 1'b1;
    step();

    // Free way 2 is the lowest invalid one; request accepted in the first REQ cycle.
    req_ready_i = 1'b1;
    full_refill(20'h001A2, 6'd5, 2'd0, 4'b1011, 4'b0100, 32'h1000_0000);

    // All ways valid: round-robin walks 0..3 and wraps.
    full_refill(20'h00010, 6'd1, 2'd0, 4'b1111, 4'b0001, 32'h2000_0000);
    full_refill(20'h00011, 6'd2, 2'd0, 4'b1111, 4'b0010, 32'h2100_0000);
    full_refill(20'h00012, 6'd3, 2'd0, 4'b1111, 4'b0100, 32'h2200_0000);
    full_refill(20'h00013, 6'd4, 2'd0, 4'b1111, 4'b1000, 32'h2300_0000);
    full_refill(20'h00014, 6'd5, 2'd0, 4'b1111, 4'b0001, 32'h2400_0000);

    // Request held for 5 cycles without ready, address stable, then completes.
    start_miss(20'hABCDE, 6'd33, 2'd0, 4'b1110, 4'b0001, 1'b1, 32'h3000_0000);
    for (int c = 0; c < 5; c++) begin
      check("stall_req_valid", req_valid_o, 1'b1);
      check("stall_req_tag", req_tag_o, 20'hABCDE);
      check("stall_req_idx", req_idx_o, 6'd33);
      step();
    end
    handshake();
    for (int b = 0; b < 4; b++) send_beat(32'h3000_0000, b);
    finish_write(1'b1);

    // Kill on the third REQ cycle before any handshake.
    start_miss(20'h0BEEF, 6'd7, 2'd0, 4'b1111, 4'b0000, 1'b0, 32'h4000_0000);
    step();
    step();
    kill_i = 1'b1;
    step();
    kill_i = 1'b0;
    check("kill_req_valid", req_valid_o, 1'b0);
    check("kill_req_busy", busy_o, 1'b0);
    for (int c = 0; c < 3; c++) begin
      check("kill_req_no_wr", wr_en_o, 1'b0);
      step();
    end

    // Kill after beat 1: remaining beats drained, no write, pointer unchanged (still way 1).
    start_miss(20'h0C0DE, 6'd9, 2'd0, 4'b1111, 4'b0000, 1'b0, 32'h5000_0000);
    handshake();
    send_beat(32'h5000_0000, 0);
    send_beat(32'h5000_0000, 1);
    kill_i = 1'b1;
    step();
    kill_i = 1'b0;
    cur_killed = 1'b1;
    send_beat(32'h5000_0000, 2);
    check("kill_wait_busy", busy_o, 1'b1);
    send_beat(32'h5000_0000, 3);
    finish_write(1'b0);
    full_refill(20'h0C0DF, 6'd10, 2'd0, 4'b1111, 4'b0010, 32'h5100_0000);

    // Gapped beats with fetch chunk 2.
    start_miss(20'h00F00, 6'd12, 2'd2, 4'b0111, 4'b1000, 1'b1, 32'h6000_0000);
    handshake();
    for (int b = 0; b < 4; b++) begin
      send_beat(32'h6000_0000, b);
      if (b < 3) begin
        for (int g = 0; g < 2; g++) begin
          check("fwd_gap", fwd_valid_o, 1'b0);
          step();
        end
      end
    end
    finish_write(1'b1);

    // Asynchronous reset in WAIT after beat 2 drops the refill and the pointer.
    start_miss(20'h07777, 6'd20, 2'd0, 4'b1111, 4'b0000, 1'b0, 32'h7000_0000);
    handshake();
    for (int b = 0; b < 3; b++) send_beat(32'h7000_0000, b);
    #2;
    rstn_i = 1'b0;
    #1;
    check("mid_rst_busy", busy_o, 1'b0);
    check("mid_rst_req_valid", req_valid_o, 1'b0);
    check("mid_rst_wr_en", wr_en_o, 1'b0);
    check("mid_rst_done", done_o, 1'b0);
    check("mid_rst_fwd", fwd_valid_o, 1'b0);
    step();
    step();
    rstn_i = 1'b1;
    resp_valid_i = 1'b1;
    resp_data_i = beat_val(32'h7000_0000, 3);
    step();
    resp_valid_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("post_rst_no_wr", wr_en_o, 1'b0);
      check("post_rst_idle", busy_o, 1'b0);
      step();
    end
    full_refill(20'h08888, 6'd21, 2'd1, 4'b1111, 4'b0001, 32'h8000_0000);

    step();
    check("sb_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/sargantana_icache_refill.md
SARGANTANA_ICACHE_REFILL -- requirements
Module: sargantana_icache_refill

Interface
REQ-001 SHALL have parameter BEAT_W, default 128, memory response beat width in bits.
REQ-002 SHALL have parameter N_BEATS, default WAY_WIDHT/BEAT_W (4), beats per cache line.
REQ-003 SHALL have port clk_i  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rstn_i  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port miss_i  input  1  miss request, sampled only in IDLE.
REQ-006 SHALL have port miss_tag_i  input  TAG_WIDHT  physical tag of missing line.
REQ-007 SHALL have port miss_idx_i  input  ICACHE_IDX_WIDTH  set index of missing line.
REQ-008 SHALL have port fetch_idx_i  input  2  requested 128b chunk within line.
REQ-009 SHALL have port way_valid_bits_i  input  ICACHE_N_WAY  valid bits of addressed set.
REQ-010 SHALL have port kill_i  input  1  abort current refill.
REQ-011 SHALL have port req_valid_o / req_ready_i  output/input  1/1  line request handshake.
REQ-012 SHALL have port req_tag_o, req_idx_o  output  TAG_WIDHT, ICACHE_IDX_WIDTH  requested line address.
REQ-013 SHALL have port resp_valid_i  input  1  beat valid; no backpressure.
REQ-014 SHALL have port resp_data_i  input  BEAT_W  beat data, beat 0 = line bits [127:0].
REQ-015 SHALL have port wr_en_o  output  1  one-cycle array write strobe.
REQ-016 SHALL have ports wr_way_o, wr_idx_o, wr_tag_o, wr_data_o  output  ICACHE_N_WAY one-hot, ICACHE_IDX_WIDTH, TAG_WIDHT, WAY_WIDHT  write target and contents.
REQ-017 SHALL have ports busy_o, done_o  output  1, 1  refill in progress; completion pulse.
REQ-018 SHALL have ports fwd_valid_o, fwd_data_o  output  1, FETCH_WIDHT  early-forwarded chunk.

Function
REQ-019 SHALL implement FSM IDLE, REQ, WAIT, WRITE; busy_o = (state != IDLE).
REQ-020 IDLE: miss_i=1 SHALL latch tag, idx, fetch_idx, victim way, go REQ next cycle; miss_i in other states ignored.
REQ-021 Victim SHALL be lowest-index way with way_valid_bits_i=0; if all valid, the round-robin pointer way.
REQ-022 Round-robin pointer SHALL advance by 1 (mod ICACHE_N_WAY) only on a completed write that used it.
REQ-023 REQ: req_valid_o=1 with stable req_tag_o/req_idx_o until req_valid_o&req_ready_i, then WAIT.
REQ-024 WAIT: each resp_valid_i SHALL store beat at beat counter position, counter +1; resp_valid_i outside WAIT ignored.
REQ-025 On beat N_BEATS-1 accepted, counter SHALL wrap to 0 and FSM go WRITE next cycle.
REQ-026 WRITE: wr_en_o=1 and done_o=1 for exactly one cycle with assembled line, latched tag/idx/way; then IDLE.
REQ-027 kill_i in REQ before handshake SHALL return to IDLE next cycle with req_valid_o=0, no write.
REQ-028 kill_i in WAIT (or same cycle as handshake) SHALL set killed flag; remaining beats still consumed; WRITE cycle then has wr_en_o=0, done_o=0, pointer unchanged.
REQ-029 kill_i in WRITE or IDLE SHALL be ignored.
REQ-030 wr_data_o, wr_way_o, wr_tag_o, wr_idx_o SHALL be don't-care when wr_en_o=0; fwd_data_o don't-care when fwd_valid_o=0.

Reset
REQ-031 rstn_i=0 SHALL immediately force IDLE, beat counter 0, pointer 0, killed flag 0.
REQ-032 During and after reset req_valid_o, wr_en_o, done_o, busy_o, fwd_valid_o SHALL be 0; reset mid-refill drops the refill without write.

Configuration
REQ-033 Macro ICACHE_EARLY_FWD_EN defined: fwd_valid_o SHALL pulse in the cycle the beat index equal to latched fetch_idx is accepted (not killed), fwd_data_o = {128'b0, resp_data_i}.
REQ-034 Macro undefined: fwd_valid_o and fwd_data_o SHALL be tied 0; no other behaviour changes.

Verification
REQ-035 Miss tag=0x1A2, idx=5, valid=4'b1011, ready same cycle, 4 beats back-to-back -> wr_en_o 1 cycle, wr_way_o=4'b0100, line = beats concatenated, done_o=1.
REQ-036 Four misses with valid=4'b1111 -> wr_way_o 0001, 0010, 0100, 1000, then 0001 again.
REQ-037 req_ready_i held low 5 cycles -> req_valid_o and address stable 5 cycles; kill_i on cycle 3 -> IDLE, no request accepted, no write.
REQ-038 kill_i after beat 1, beats 2-3 arrive -> wr_en_o=0, done_o=0, next miss accepted normally, pointer unchanged.
REQ-039 ICACHE_EARLY_FWD_EN, fetch_idx=2, beats gapped by idle cycles -> fwd_valid_o once, on beat 2, data = beat 2; without macro fwd_valid_o stays 0.
REQ-040 rstn_i low during WAIT after beat 2 -> all outputs 0 immediately, no wr_en_o after release, fresh miss completes correctly.
